// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, divisor floor and parity modes.
// The receive path is expected to import this package as well.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // A bit period shorter than two clocks leaves no room for the registered outputs.
    localparam int MIN_DIV = 2;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter: counts div-1 down to 0 and reloads on every bit boundary.
// bit_tick marks the last clock of a bit; pre_tick marks the clock before it.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Resetn,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 bit_tick,
    output logic                 pre_tick
);

    logic [DIV_WIDTH-1:0] cnt;

    // Reloading from div on the terminal count keeps every bit exactly div clocks, with no drift.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            cnt <= '0;
        end else if (load || cnt == '0) begin
            cnt <= div - DIV_WIDTH'(1);
        end else begin
            cnt <= cnt - DIV_WIDTH'(1);
        end
    end

    assign bit_tick = !load && (cnt == '0);
    assign pre_tick = !load && (cnt == DIV_WIDTH'(1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops one byte per frame from the TX FIFO and serialises it as
// start, data LSB-first, optional parity and one or two stop bits. All outputs are registered.
import uart_pkg::*;

module uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  two_stop,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      bit_idx, bit_idx_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d, div_clamped, div_in;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  two_stop_q, two_stop_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  tx_d, done_d;
    logic                  baud_load, bit_tick, pre_tick;

    assign div_clamped = (baud_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : baud_div;
    assign baud_load   = (state == LOAD);
    assign div_in      = baud_load ? div_clamped : div_q;

    uart_baud_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_baud (
        .Clk     (Clk),
        .Resetn  (Resetn),
        .load    (baud_load),
        .div     (div_in),
        .bit_tick(bit_tick),
        .pre_tick(pre_tick)
    );

    // FIFO handshake: fifo_rd_en is a one-cycle pop strobe raised only in FETCH, which is
    // entered only after fifo_empty was seen low; the FIFO's registered read data is valid
    // the following cycle (LOAD), where it is captured along with the frame configuration.
    always_comb begin
        state_d    = state;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx;
        div_d      = div_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx;
        done_d     = 1'b0;
        case (state)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d    = fifo_data;
                div_d      = div_clamped;
                par_en_d   = parity_en;
                par_bit_d  = (^fifo_data) ^ parity_odd;
                two_stop_d = two_stop;
                tx_d       = 1'b0;
                state_d    = START;
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx == LAST_IDX) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = STOP;
                            stop_idx_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx + IDX_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            STOP: begin
                // Registered strobe: armed one clock early so it lands on the frame's last clock.
                done_d = pre_tick && (!two_stop_q || stop_idx_q);
                if (bit_tick) begin
                    if (two_stop_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state      <= IDLE;
            shift_q    <= '0;
            bit_idx    <= '0;
            div_q      <= DIV_WIDTH'(MIN_DIV);
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_idx_q <= 1'b0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_d;
            shift_q    <= shift_d;
            bit_idx    <= bit_idx_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            stop_idx_q <= stop_idx_d;
            tx         <= tx_d;
            fifo_rd_en <= (state_d == FETCH);
            busy       <= (state_d != IDLE);
            tx_done    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a FIFO model feeds frames; expected line activity is built per frame
// from the UART framing rules and compared cycle by cycle, plus table vectors and reset cases.
module tb_uart_tx;

    localparam int DW = 8;
    localparam int VW = 16;

    logic          Clk = 1'b0;
    logic          Resetn;
    logic [VW-1:0] baud_div;
    logic          parity_en, parity_odd, two_stop;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_rd_en, tx, busy, tx_done;

    uart_tx #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
        .Clk       (Clk),
        .Resetn    (Resetn),
        .baud_div  (baud_div),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .two_stop  (two_stop),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    // Clock/reset: negedges at 10, 20, ...; all driving and sampling happens there.
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic        pe, po, ts;
    } frame_t;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic        pe, po, ts;
        int          exp_len;
        logic        exp_par;
    } vec_t;

    frame_t     frames[$];
    logic [7:0] fifo_q[$];
    logic [3:0] exp_q[$];   // {rd_en, busy, tx_done, tx} per cycle
    logic [3:0] obs_q[$];
    int         load_at[$];
    int         total, bad;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Advance to the next negedge and service the FIFO read port.
    task automatic step();
        @(negedge Clk);
        if (fifo_rd_en) begin
            total++;
            if (fifo_q.size() == 0) begin
                bad++;
                $display("FAIL pop_when_empty: got rd_en=1 with 0 entries, required rd_en=0");
            end else begin
                fifo_data = fifo_q.pop_front();
            end
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic apply_cfg(input frame_t f);
        baud_div   = f.div;
        parity_en  = f.pe;
        parity_odd = f.po;
        two_stop   = f.ts;
    endtask

    task automatic rand_cfg();
        baud_div   = VW'($urandom_range(0, 9));
        parity_en  = 1'($urandom_range(0, 1));
        parity_odd = 1'($urandom_range(0, 1));
        two_stop   = 1'($urandom_range(0, 1));
    endtask

    // Reference model: frame = bit list, each bit held for max(div,2) clocks.
    task automatic build_expected();
        exp_q.delete();
        load_at.delete();
        foreach (frames[j]) begin
            logic bits[$];
            int   d;
            d = (frames[j].div < 2) ? 2 : int'(frames[j].div);
            if (j > 0) exp_q.push_back(4'b0001);
            exp_q.push_back(4'b1101);
            load_at.push_back(exp_q.size());
            exp_q.push_back(4'b0101);
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(frames[j].data[i]);
            if (frames[j].pe)
                bits.push_back(1'(($countones(frames[j].data) + (frames[j].po ? 1 : 0)) % 2));
            bits.push_back(1'b1);
            if (frames[j].ts) bits.push_back(1'b1);
            for (int b = 0; b < bits.size(); b++)
                for (int c = 0; c < d; c++)
                    exp_q.push_back({1'b0, 1'b1, (b == bits.size() - 1) && (c == d - 1), bits[b]});
        end
        for (int i = 0; i < 10; i++) exp_q.push_back(4'b0001);
    endtask

    // Must be entered at a negedge with the DUT idle. Each frame's config is held through
    // its LOAD and then replaced by the next frame's (or random) values mid-frame.
    task automatic run_frames(input string name);
        int nbad, first_bad;
        build_expected();
        obs_q.delete();
        apply_cfg(frames[0]);
        foreach (frames[j]) fifo_q.push_back(frames[j].data);
        fifo_empty = 1'b0;
        nbad = 0;
        first_bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            step();
            obs_q.push_back({fifo_rd_en, busy, tx_done, tx});
            if (obs_q[i] !== exp_q[i]) begin
                nbad++;
                if (first_bad < 0) first_bad = i;
            end
            for (int j = 0; j < load_at.size(); j++)
                if (i == load_at[j] + 1) begin
                    if (j + 1 < frames.size()) apply_cfg(frames[j + 1]);
                    else rand_cfg();
                end
        end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s: %0d cycles differ, first at cycle %0d got {rd,busy,done,tx}=%b required %b",
                     name, nbad, first_bad, obs_q[first_bad], exp_q[first_bad]);
        end
    endtask

    function automatic int find_from(input int bitpos, input logic val, input int from);
        if (from < 0) return -1;
        for (int i = from; i < obs_q.size(); i++)
            if (obs_q[i][bitpos] == val) return i;
        return -1;
    endfunction

    function automatic int count_bit(input int bitpos);
        int n = 0;
        foreach (obs_q[i]) if (obs_q[i][bitpos]) n++;
        return n;
    endfunction

    function automatic int obs_tx(input int i);
        if (i < 0 || i >= obs_q.size()) return -1;
        return int'(obs_q[i][0]);
    endfunction

    vec_t vecs[8];

    initial begin
        int s, dn, s2, dn2, d;
        total = 0;
        bad   = 0;
        vecs[0] = '{8'h55, 16'd4, 1'b0, 1'b0, 1'b0, 40, 1'b0};
        vecs[1] = '{8'hA5, 16'd3, 1'b1, 1'b0, 1'b0, 33, 1'b0};
        vecs[2] = '{8'h07, 16'd3, 1'b1, 1'b0, 1'b0, 33, 1'b1};
        vecs[3] = '{8'hA5, 16'd3, 1'b1, 1'b1, 1'b0, 33, 1'b1};
        vecs[4] = '{8'h07, 16'd3, 1'b1, 1'b1, 1'b0, 33, 1'b0};
        vecs[5] = '{8'hFF, 16'd4, 1'b0, 1'b0, 1'b1, 44, 1'b0};
        vecs[6] = '{8'h01, 16'd0, 1'b0, 1'b0, 1'b0, 20, 1'b0};
        vecs[7] = '{8'h02, 16'd1, 1'b0, 1'b0, 1'b0, 20, 1'b0};

        Resetn = 1'b0;
        baud_div = 16'd4;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        two_stop = 1'b0;
        fifo_data = '0;
        fifo_empty = 1'b1;
        #13;
        check("reset_tx", int'(tx), 1);
        check("reset_rd_en", int'(fifo_rd_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_tx_done", int'(tx_done), 0);
        step();
        Resetn = 1'b1;
        step();
        step();

        // Table vectors: full trace plus frame length, start latency and parity bit.
        for (int v = 0; v < 8; v++) begin
            frames.delete();
            frames.push_back('{vecs[v].data, vecs[v].div, vecs[v].pe, vecs[v].po, vecs[v].ts});
            run_frames($sformatf("vec%0d_trace", v));
            s  = find_from(0, 1'b0, 0);
            dn = find_from(1, 1'b1, 0);
            check($sformatf("vec%0d_start_latency", v), s, 2);
            check($sformatf("vec%0d_frame_len", v), dn - s + 1, vecs[v].exp_len);
            check($sformatf("vec%0d_rd_pulses", v), count_bit(3), 1);
            if (vecs[v].pe) begin
                d = (vecs[v].div < 2) ? 2 : int'(vecs[v].div);
                check($sformatf("vec%0d_parity", v), obs_tx(s + 9 * d + d / 2), int'(vecs[v].exp_par));
            end
        end

        // Back-to-back frames with three-cycle idle gaps, then an empty FIFO.
        frames.delete();
        for (int k = 1; k <= 3; k++) frames.push_back('{8'(k), 16'd3, 1'b0, 1'b0, 1'b0});
        run_frames("b2b_trace");
        check("b2b_rd_pulses", count_bit(3), 3);
        check("b2b_done_pulses", count_bit(1), 3);
        dn = find_from(1, 1'b1, 0);
        s2 = find_from(0, 1'b0, dn + 1);
        check("b2b_gap", s2 - dn - 1, 3);

        // Divisor changed 4 -> 8 in the middle of the first frame.
        frames.delete();
        frames.push_back('{8'h5A, 16'd4, 1'b0, 1'b0, 1'b0});
        frames.push_back('{8'h5A, 16'd8, 1'b0, 1'b0, 1'b0});
        run_frames("div_change_trace");
        s   = find_from(0, 1'b0, 0);
        dn  = find_from(1, 1'b1, 0);
        s2  = find_from(0, 1'b0, dn + 1);
        dn2 = find_from(1, 1'b1, dn + 1);
        check("div_change_len0", dn - s + 1, 40);
        check("div_change_len1", dn2 - s2 + 1, 80);

        // Randomised frames and configurations.
        for (int r = 0; r < 20; r++) begin
            int n;
            frames.delete();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                frame_t f;
                f.data = 8'($urandom_range(0, 255));
                f.div  = 16'($urandom_range(0, 6));
                f.pe   = 1'($urandom_range(0, 1));
                f.po   = 1'($urandom_range(0, 1));
                f.ts   = 1'($urandom_range(0, 1));
                frames.push_back(f);
            end
            run_frames($sformatf("rand%0d_trace", r));
        end

        // Reset asserted during data bit 3 of 0x00.
        frames.delete();
        frames.push_back('{8'h00, 16'd4, 1'b0, 1'b0, 1'b0});
        apply_cfg(frames[0]);
        fifo_q.push_back(8'h00);
        fifo_empty = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("mid_frame_tx_low", int'(tx), 0);
        check("mid_frame_busy", int'(busy), 1);
        #2;
        Resetn = 1'b0;
        fifo_q.delete();
        fifo_empty = 1'b1;
        #1;
        check("async_reset_tx", int'(tx), 1);
        check("async_reset_rd_en", int'(fifo_rd_en), 0);
        check("async_reset_busy", int'(busy), 0);
        step();
        step();
        Resetn = 1'b1;
        step();
        frames.delete();
        frames.push_back('{8'h3C, 16'd3, 1'b1, 1'b0, 1'b0});
        run_frames("after_reset_trace");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
